// File: rtl/shared_and_arbiter_pkg.sv
// Shared types and helpers for the shared AND-unit arbiter.
// OPCNT_W sizes the optional completion counter (SHARED_AND_STATS_EN).
package shared_and_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int OPCNT_W = 16;

    // Index width, never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_and_arbiter_if.sv
// Requester-side bus of the shared AND-unit arbiter.
// OPCNT exists only when SHARED_AND_STATS_EN is defined.
interface shared_and_arbiter_if
    import shared_and_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = idw(N);

    logic [N-1:0]       REQ;
    logic [N*WIDTH-1:0] I0;
    logic [N*WIDTH-1:0] I1;
    logic [N-1:0]       GNT;
    logic [WIDTH-1:0]   Z;
    logic               ZV;
    logic [IDW-1:0]     ZID;
    logic               BUSY;
`ifdef SHARED_AND_STATS_EN
    logic [OPCNT_W-1:0] OPCNT;

    modport master (output REQ, I0, I1, input GNT, Z, ZV, ZID, BUSY, OPCNT);
    modport slave  (input REQ, I0, I1, output GNT, Z, ZV, ZID, BUSY, OPCNT);
`else
    modport master (output REQ, I0, I1, input GNT, Z, ZV, ZID, BUSY);
    modport slave  (input REQ, I0, I1, output GNT, Z, ZV, ZID, BUSY);
`endif

endinterface

// File: rtl/shared_and_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request above ptr, modulo N.
module rr_pick
    import shared_and_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    always_comb begin
        logic [IDW-1:0] kk;
        logic           found;
        kk    = '0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        any   = |req;
        for (int i = 1; i <= N; i++) begin
            kk = IDW'((int'(ptr) + i) % N);
            if (!found && req[kk]) begin
                found   = 1'b1;
                gnt[kk] = 1'b1;
                idx     = kk;
            end
        end
    end

endmodule

// File: rtl/shared_and_arbiter.sv
// Round-robin sharing of one fixed-delay (DIZ) bitwise AND unit among N requesters.
// SHARED_AND_STATS_EN adds a saturating completion counter on OPCNT.
//
//   state   | meaning
//   ST_IDLE | unit free, grant on any request
//   ST_BUSY | operation in flight, counter running down to 0
//   ST_DONE | result valid (ZV), may grant the next request in the same cycle
module shared_and_arbiter
    import shared_and_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int DIZ   = 6
) (
    input logic                 CK,
    input logic                 _CLR,
    shared_and_arbiter_if.slave bus
);

    localparam int IDW = idw(N);
    localparam int CW  = idw(DIZ);
    localparam logic [CW-1:0] CNT_INIT = (DIZ > 1) ? CW'(DIZ - 2) : '0;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, zid_q, zid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [N-1:0]     pick_gnt, gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

    rr_pick #(.N(N)) u_pick (
        .req (bus.REQ),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N; k++) begin
            if (pick_gnt[k]) begin
                sel_a = sel_a | bus.I0[k*WIDTH +: WIDTH];
                sel_b = sel_b | bus.I1[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        z_d     = z_q;
        zid_d   = zid_q;
        gnt     = '0;
        case (state_q)
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    z_d     = a_q & b_q;
                    zid_d   = id_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (pick_any) begin
                    gnt   = pick_gnt;
                    ptr_d = pick_idx;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    id_d  = pick_idx;
                    // With a one-cycle unit the grant edge is also the completion edge.
                    if (DIZ == 1) begin
                        state_d = ST_DONE;
                        z_d     = sel_a & sel_b;
                        zid_d   = pick_idx;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CK or negedge _CLR) begin
        if (!_CLR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDW'(N - 1);
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            z_q     <= '0;
            zid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            z_q     <= z_d;
            zid_q   <= zid_d;
        end
    end

    // Grant is masked while reset is held so no request can be seen as granted.
    assign bus.GNT  = _CLR ? gnt : '0;
    assign bus.Z    = z_q;
    assign bus.ZV   = (state_q == ST_DONE);
    assign bus.ZID  = zid_q;
    assign bus.BUSY = (state_q == ST_BUSY);

`ifdef SHARED_AND_STATS_EN
    logic [OPCNT_W-1:0] opcnt_q, opcnt_d;

    always_comb begin
        opcnt_d = opcnt_q;
        if (state_q == ST_DONE && opcnt_q != '1) opcnt_d = opcnt_q + 1'b1;
    end

    always_ff @(posedge CK or negedge _CLR) begin
        if (!_CLR) opcnt_q <= '0;
        else       opcnt_q <= opcnt_d;
    end

    assign bus.OPCNT = opcnt_q;
`endif

endmodule

// File: tb/tb_shared_and_arbiter.sv
// Directed bench for shared_and_arbiter (DIZ=6 and DIZ=1 instances) with a grant/result scoreboard.
module tb_shared_and_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 6;

    typedef struct {
        int         due;
        logic [1:0] id;
        logic [7:0] z;
    } exp_t;

    logic CK = 1'b0;
    logic CLR_N = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_rem = 0;
    int   ptr_m = N - 1;
    exp_t q[$];

    shared_and_arbiter_if #(.N(N), .WIDTH(W)) b6 ();
    shared_and_arbiter_if #(.N(N), .WIDTH(W)) b1 ();

    shared_and_arbiter #(.N(N), .WIDTH(W), .DIZ(D)) dut6 (.CK(CK), ._CLR(CLR_N), .bus(b6.slave));
    shared_and_arbiter #(.N(N), .WIDTH(W), .DIZ(1)) dut1 (.CK(CK), ._CLR(CLR_N), .bus(b1.slave));

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic wait_zv();
        for (int i = 0; i < 20 && b6.ZV !== 1'b1; i++) tick();
        chk("zv_timeout", {31'd0, b6.ZV}, 32'd1);
    endtask

    // Scoreboard for the DIZ=6 instance: grants and busy from an occupancy model, results from the queue.
    always @(negedge CK) begin
        logic [N-1:0] eg;
        logic [1:0]   kk;
        logic         found;
        exp_t         e;
        if (!CLR_N) begin
            q.delete();
            m_rem = 0;
            ptr_m = N - 1;
        end else begin
            cyc++;
            if (m_rem > 0) m_rem--;
            eg = '0;
            kk = '0;
            found = 1'b0;
            if (m_rem == 0) begin
                for (int i = 1; i <= N; i++) begin
                    kk = 2'((ptr_m + i) % N);
                    if (!found && b6.REQ[kk]) begin
                        found = 1'b1;
                        eg[kk] = 1'b1;
                    end
                end
            end
            chk("sb_gnt", {28'd0, b6.GNT}, {28'd0, eg});
            chk("sb_busy", {31'd0, b6.BUSY}, {31'd0, (m_rem != 0)});
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("sb_zv", {31'd0, b6.ZV}, 32'd1);
                chk("sb_z", {24'd0, b6.Z}, {24'd0, e.z});
                chk("sb_zid", {30'd0, b6.ZID}, {30'd0, e.id});
            end else begin
                chk("sb_nozv", {31'd0, b6.ZV}, 32'd0);
            end
            if (found) begin
                for (int k = 0; k < N; k++) begin
                    if (eg[k]) begin
                        e.due = cyc + D;
                        e.id  = 2'(k);
                        e.z   = b6.I0[k*W +: W] & b6.I1[k*W +: W];
                        q.push_back(e);
                        ptr_m = k;
                    end
                end
                m_rem = D;
            end
        end
    end

    initial begin
        int         ng;
        int         g1;
        int         nzv;
        logic [7:0] op0, op1;
        b6.REQ = '0; b6.I0 = '0; b6.I1 = '0;
        b1.REQ = '0; b1.I0 = '0; b1.I1 = '0;
        #1;
        chk("rst_zv", {31'd0, b6.ZV}, 32'd0);
        chk("rst_busy", {31'd0, b6.BUSY}, 32'd0);
        chk("rst_z", {24'd0, b6.Z}, 32'd0);
        chk("rst_zid", {30'd0, b6.ZID}, 32'd0);
        tick(); tick();
        CLR_N = 1'b1;
        tick();

        // Single request from requester 2.
        b6.I0[2*W +: W] = 8'hF0;
        b6.I1[2*W +: W] = 8'h3C;
        b6.REQ = 4'b0100;
        #1;
        chk("single_gnt", {28'd0, b6.GNT}, 32'h4);
        tick();
        b6.REQ = '0;
        for (int i = 1; i <= 5; i++) begin
            chk("single_busy", {31'd0, b6.BUSY}, 32'd1);
            chk("single_nozv", {31'd0, b6.ZV}, 32'd0);
            tick();
        end
        chk("single_zv", {31'd0, b6.ZV}, 32'd1);
        chk("single_z", {24'd0, b6.Z}, 32'h30);
        chk("single_zid", {30'd0, b6.ZID}, 32'd2);
        tick(); tick();

        // Reset three cycles into an operation for requester 1.
        b6.REQ = 4'b0010;
        #1;
        chk("pre_rst_gnt", {28'd0, b6.GNT}, 32'h2);
        tick();
        b6.REQ = '0;
        tick(); tick();
        CLR_N = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, b6.BUSY}, 32'd0);
        chk("midrst_zv", {31'd0, b6.ZV}, 32'd0);
        chk("midrst_z", {24'd0, b6.Z}, 32'd0);
        chk("midrst_zid", {30'd0, b6.ZID}, 32'd0);
        chk("midrst_gnt", {28'd0, b6.GNT}, 32'd0);
        tick(); tick();
        CLR_N = 1'b1;
        tick();

        // Continuous demand from all four requesters.
        b6.I0 = $urandom;
        b6.I1 = $urandom;
        b6.REQ = 4'b1111;
        #1;
        ng = 0;
        for (int c = 0; c < 25; c++) begin
            if (b6.GNT != '0) begin
                chk("rr_order", {28'd0, b6.GNT}, 32'd1 << (ng % N));
                if (ng > 0) chk("rr_zv_with_gnt", {31'd0, b6.ZV}, 32'd1);
                ng++;
            end
            tick();
        end
        chk("rr_grant_count", ng, 5);
        b6.REQ = '0;
        for (int i = 0; i < 8; i++) tick();

        // Requester 1 drops its request while requester 0 holds the unit.
        b6.REQ = 4'b0001;
        #1;
        chk("drop_gnt0", {28'd0, b6.GNT}, 32'h1);
        tick();
        b6.REQ = 4'b0010;
        tick(); tick();
        b6.REQ = '0;
        g1 = 0;
        nzv = 0;
        for (int i = 0; i < 12; i++) begin
            if (b6.GNT[1]) g1++;
            if (b6.ZV) nzv++;
            tick();
        end
        chk("drop_never_granted", g1, 0);
        chk("drop_one_zv", nzv, 1);

        // One-cycle unit: two requesters alternate every cycle.
        b1.I0 = $urandom;
        b1.I1 = $urandom;
        op0 = b1.I0[0 +: W] & b1.I1[0 +: W];
        op1 = b1.I0[W +: W] & b1.I1[W +: W];
        b1.REQ = 4'b0011;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("diz1_gnt", {28'd0, b1.GNT}, (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("diz1_busy", {31'd0, b1.BUSY}, 32'd0);
            if (i == 0) begin
                chk("diz1_nozv", {31'd0, b1.ZV}, 32'd0);
            end else begin
                chk("diz1_zv", {31'd0, b1.ZV}, 32'd1);
                chk("diz1_zid", {30'd0, b1.ZID}, 32'((i - 1) % 2));
                chk("diz1_z", {24'd0, b1.Z}, {24'd0, ((i - 1) % 2 == 0) ? op0 : op1});
            end
            tick();
        end
        b1.REQ = '0;
        tick(); tick();

`ifdef SHARED_AND_STATS_EN
        force dut6.opcnt_q = 16'hFFFE;
        tick();
        release dut6.opcnt_q;
        for (int r = 0; r < 3; r++) begin
            b6.REQ = 4'b0100;
            tick();
            b6.REQ = '0;
            wait_zv();
            tick();
            chk("opcnt_sat", {16'd0, b6.OPCNT}, 32'hFFFF);
        end
`endif
        b6.REQ = 4'b1000;
        tick();
        b6.REQ = '0;
        wait_zv();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_and_arbiter.md
Name: shared_and_arbiter

Overview:
- Shares one WIDTH-bit bitwise AND2 evaluation unit with fixed delay DIZ between N requesters.
- Round-robin grant, one operation in flight at a time; result returned with requester ID.
- Sits between requester logic and a single delayed AND unit and sequences all access to it.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits
DIZ, 6, unit delay in clock cycles from grant to result (>=1)

Ports:
CK  input  1  clock, all state updates on rising edge
_CLR  input  1  reset, asynchronous, active-low
REQ  input  N  per-requester request; held until the matching GNT bit is seen
I0  input  N*WIDTH  operand A, requester k in bits [k*WIDTH +: WIDTH]
I1  input  N*WIDTH  operand B, same packing
GNT  output  N  one-hot grant, combinational, high only in grant cycle
Z  output  WIDTH  registered result, I0&I1 of the granted requester
ZV  output  1  result valid, one-cycle pulse
ZID  output  clog2(N)  index of requester owning Z
BUSY  output  1  high while an operation is in flight (state BUSY)

Behaviour:
- Interface: one clock CK; reset _CLR asynchronous, active-low.
- Reset values: state IDLE, Z=0, ZV=0, ZID=0, BUSY=0, GNT=0, delay counter=0, RR pointer=N-1, so requester 0 has first priority.
- States:
  - IDLE: no REQ -> stay. Any REQ -> grant, capture, go BUSY (DIZ>1) or DONE (DIZ=1).
  - BUSY: counter counts down from DIZ-2. At 0 -> DONE. GNT=0.
  - DONE: ZV=1, Z/ZID reflect the completed op. If any REQ -> grant in this same cycle and go BUSY/DONE as from IDLE. Otherwise -> IDLE.
- Grant:
  - Combinational in IDLE and DONE only.
  - Pick the first asserted REQ searching from pointer+1 upward, modulo N.
  - At the grant edge: pointer <- granted index; operands and index are captured into holding registers.
- Result: Z <- captured I0 & I1 and ZID <- captured index on the edge entering DONE. Both hold until the next completion.
- Latency: ZV is high exactly DIZ cycles after the GNT cycle. Throughput is one operation per DIZ cycles under continuous demand.
- Requester contract: REQ and operands must be stable in the GNT cycle. A REQ dropped before grant is never granted. REQ changes after grant are ignored.
- Simultaneous requests: exactly one GNT bit per grant cycle, never zero GNT bits while in IDLE/DONE with REQ nonzero.
- DONE with new request: ZV for the old op and GNT for the new op are asserted in the same cycle.
- Reset mid-operation: the in-flight op is discarded, no ZV, all state returns to reset values immediately.
- Width: the AND is bitwise, with no extension or truncation.

Optional Feature:
SHARED_AND_STATS_EN
- Defined: adds output OPCNT [15:0]. It increments on every ZV pulse, saturates at 16'hFFFF and resets to 0.
- Undefined: no port, no counter. Behaviour is otherwise identical.

Decomposition:
- Package shared_and_pkg holds:
  - state enum (IDLE, BUSY, DONE)
  - IDW = clog2(N) helper function
  - OPCNT width constant
- Sub-module rr_pick:
  - purely combinational round-robin one-hot picker
  - inputs: REQ, pointer
  - outputs: one-hot GNT, encoded index, any-request flag
- The top holds the FSM, counter, capture registers and result registers.

Test Plan:
- Reset check: hold _CLR low mid-operation (DIZ=6, grant issued 3 cycles earlier) -> outputs zero immediately, no ZV afterward, first later grant goes to requester 0.
- Single request, requester 2 only, I0=8'hF0, I1=8'h3C -> GNT=4'b0100 one cycle; ZV exactly 6 cycles later; Z=8'h30, ZID=2; BUSY high for the 5 cycles between.
- All four REQ held high continuously -> grants cycle 0,1,2,3,0. Each ZV coincides with the next GNT. ZV spacing is 6 cycles.
- DIZ=1 build, REQ=4'b0011 held -> GNT alternates 01/10 every cycle; ZV every cycle from the second cycle; ZID alternates 0,1.
- Requester 1 raises REQ, then drops it before grant while requester 0 holds the unit -> requester 1 never granted; no extra ZV.
- With SHARED_AND_STATS_EN, counter preloaded via forced state to 16'hFFFE, then 3 completions -> OPCNT reads FFFF, FFFF, FFFF and never wraps.
